reduction_dispatch_scheduler: RTL and testbench

REDUCTION_DISPATCH_SCHEDULER -- requirements
Module: reduction_dispatch_scheduler

---
 rtl/reduction_dispatch_scheduler_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/reduction_dispatch_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_reduction_dispatch_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduction_dispatch_scheduler_pkg.sv
// Shared types and defaults for the column reduction dispatch scheduler.
// Also reused by the TDA top level for sizing.
package reduction_dispatch_scheduler_pkg;

   localparam int unsigned DefaultNumUnits  = 8;
   localparam int unsigned DefaultAddrWidth = 12;

   typedef enum logic [1:0] {
      StIdle,
      StDispatch,
      StDrain
   } sched_state_e;

   // Increment an index modulo n.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational.
module rr_arbiter #(
   parameter int unsigned N = 8,
   parameter int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_valid
);

   int unsigned    sum;
   logic [W-1:0]   idx;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      sum       = 0;
      idx       = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sum = 32'(ptr) + i;
         if (sum >= N) sum = sum - N;
         idx = W'(sum);
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/reduction_dispatch_scheduler.sv
// Hands columns to reduction units round-robin, collects their completions
// and emits persistence pairs (pivot row, column) one per cycle.
module reduction_dispatch_scheduler
   import reduction_dispatch_scheduler_pkg::*;
#(
   parameter int unsigned NUM_UNITS  = DefaultNumUnits,
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
   parameter int unsigned UNIT_W     = $clog2(NUM_UNITS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [ADDR_WIDTH-1:0]           num_columns,
   output logic                            dispatch_valid,
   input  logic                            dispatch_ready,
   output logic [UNIT_W-1:0]               dispatch_unit,
   output logic [ADDR_WIDTH-1:0]           dispatch_col,
   input  logic [NUM_UNITS-1:0]            done_valid,
   input  logic [NUM_UNITS-1:0]            done_zero,
   input  logic [NUM_UNITS*ADDR_WIDTH-1:0] done_pivot,
   output logic                            pair_valid,
   input  logic                            pair_ready,
   output logic [ADDR_WIDTH-1:0]           pair_birth,
   output logic [ADDR_WIDTH-1:0]           pair_death,
   output logic                            busy,
   output logic                            complete,
   output logic                            err_spurious,
   output logic [ADDR_WIDTH:0]             pair_count
);

   sched_state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] num_cols_q, num_cols_d;
   logic [ADDR_WIDTH-1:0] col_cnt_q, col_cnt_d;
   logic [UNIT_W-1:0]     rr_disp_q, rr_disp_d;
   logic [UNIT_W-1:0]     rr_ret_q, rr_ret_d;
   logic [NUM_UNITS-1:0]  owned_q, owned_d;
   logic [NUM_UNITS-1:0]  pending_q, pending_d;
   logic [NUM_UNITS-1:0]  zero_q, zero_d;
   logic [ADDR_WIDTH-1:0] pivot_q [NUM_UNITS];
   logic [ADDR_WIDTH-1:0] pivot_d [NUM_UNITS];
   logic [ADDR_WIDTH-1:0] col_of_q [NUM_UNITS];
   logic [ADDR_WIDTH-1:0] col_of_d [NUM_UNITS];
   logic                  hold_q, hold_d;
   logic [UNIT_W-1:0]     hold_unit_q, hold_unit_d;
   logic                  pair_valid_q, pair_valid_d;
   logic [ADDR_WIDTH-1:0] pair_birth_q, pair_birth_d;
   logic [ADDR_WIDTH-1:0] pair_death_q, pair_death_d;
   logic [UNIT_W-1:0]     pair_unit_q, pair_unit_d;
   logic [ADDR_WIDTH:0]   pair_count_q, pair_count_d;
   logic                  complete_q, complete_d;
   logic                  err_q, err_d;

   logic [NUM_UNITS-1:0]  free_units;
   logic [NUM_UNITS-1:0]  inflight_mask;
   logic [NUM_UNITS-1:0]  ret_req;
   logic [UNIT_W-1:0]     disp_gnt, ret_gnt;
   logic                  disp_gnt_valid, ret_gnt_valid;
   logic                  disp_fire, pair_fire, slot_free;

   assign free_units    = ~owned_q;
   // The entry sitting in the pair register is still pending; keep it out of arbitration.
   assign inflight_mask = pair_valid_q ? (NUM_UNITS'(1) << pair_unit_q) : '0;
   assign ret_req       = pending_q & ~inflight_mask;

   rr_arbiter #(
      .N (NUM_UNITS),
      .W (UNIT_W)
   ) u_disp_arb (
      .req       (free_units),
      .ptr       (rr_disp_q),
      .gnt_idx   (disp_gnt),
      .gnt_valid (disp_gnt_valid)
   );

   rr_arbiter #(
      .N (NUM_UNITS),
      .W (UNIT_W)
   ) u_ret_arb (
      .req       (ret_req),
      .ptr       (rr_ret_q),
      .gnt_idx   (ret_gnt),
      .gnt_valid (ret_gnt_valid)
   );

   // A stalled offer is frozen so a unit freed meanwhile cannot change it.
   assign dispatch_valid = (state_q == StDispatch) && (hold_q || disp_gnt_valid);
   assign dispatch_unit  = hold_q ? hold_unit_q : disp_gnt;
   assign dispatch_col   = col_cnt_q;
   assign pair_valid     = pair_valid_q;
   assign pair_birth     = pair_birth_q;
   assign pair_death     = pair_death_q;
   assign pair_count     = pair_count_q;
   assign busy           = (state_q != StIdle);
   assign complete       = complete_q;
   assign err_spurious   = err_q;

   assign disp_fire = dispatch_valid && dispatch_ready;
   assign pair_fire = pair_valid_q && pair_ready;
   assign slot_free = !pair_valid_q || pair_ready;

   always_comb begin
      state_d      = state_q;
      num_cols_d   = num_cols_q;
      col_cnt_d    = col_cnt_q;
      rr_disp_d    = rr_disp_q;
      rr_ret_d     = rr_ret_q;
      owned_d      = owned_q;
      pending_d    = pending_q;
      zero_d       = zero_q;
      pivot_d      = pivot_q;
      col_of_d     = col_of_q;
      hold_d       = hold_q;
      hold_unit_d  = hold_unit_q;
      pair_valid_d = pair_valid_q;
      pair_birth_d = pair_birth_q;
      pair_death_d = pair_death_q;
      pair_unit_d  = pair_unit_q;
      pair_count_d = pair_count_q;
      complete_d   = complete_q;
      err_d        = err_q;

      if (disp_fire) begin
         owned_d[dispatch_unit]  = 1'b1;
         col_of_d[dispatch_unit] = col_cnt_q;
         col_cnt_d               = col_cnt_q + ADDR_WIDTH'(1);
         rr_disp_d               = UNIT_W'(wrap_inc(32'(dispatch_unit), NUM_UNITS));
         hold_d                  = 1'b0;
      end else if (dispatch_valid) begin
         hold_d      = 1'b1;
         hold_unit_d = dispatch_unit;
      end

      for (int i = 0; i < NUM_UNITS; i++) begin
         if (done_valid[i]) begin
            if (owned_q[i] && !pending_q[i]) begin
               pending_d[i] = 1'b1;
               zero_d[i]    = done_zero[i];
               pivot_d[i]   = done_pivot[i*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
               err_d = 1'b1;
            end
         end
      end

      if (pair_fire) begin
         owned_d[pair_unit_q]   = 1'b0;
         pending_d[pair_unit_q] = 1'b0;
         pair_count_d           = pair_count_q + (ADDR_WIDTH+1)'(1);
      end
      if (slot_free) pair_valid_d = 1'b0;

      if (ret_gnt_valid) begin
         if (zero_q[ret_gnt]) begin
            owned_d[ret_gnt]   = 1'b0;
            pending_d[ret_gnt] = 1'b0;
            rr_ret_d           = UNIT_W'(wrap_inc(32'(ret_gnt), NUM_UNITS));
         end else if (slot_free) begin
            pair_valid_d = 1'b1;
            pair_birth_d = pivot_q[ret_gnt];
            pair_death_d = col_of_q[ret_gnt];
            pair_unit_d  = ret_gnt;
            rr_ret_d     = UNIT_W'(wrap_inc(32'(ret_gnt), NUM_UNITS));
         end
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               num_cols_d   = num_columns;
               col_cnt_d    = '0;
               pair_count_d = '0;
               owned_d      = '0;
               pending_d    = '0;
               complete_d   = 1'b0;
               err_d        = 1'b0;
               hold_d       = 1'b0;
               state_d      = (num_columns == '0) ? StDrain : StDispatch;
            end
         end
         StDispatch: begin
            if (disp_fire && (col_cnt_q == num_cols_q - ADDR_WIDTH'(1))) state_d = StDrain;
         end
         StDrain: begin
            if ((owned_q == '0) && !pair_valid_q) begin
               state_d    = StIdle;
               complete_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         num_cols_q   <= '0;
         col_cnt_q    <= '0;
         rr_disp_q    <= '0;
         rr_ret_q     <= '0;
         owned_q      <= '0;
         pending_q    <= '0;
         zero_q       <= '0;
         for (int i = 0; i < NUM_UNITS; i++) begin
            pivot_q[i]  <= '0;
            col_of_q[i] <= '0;
         end
         hold_q       <= 1'b0;
         hold_unit_q  <= '0;
         pair_valid_q <= 1'b0;
         pair_birth_q <= '0;
         pair_death_q <= '0;
         pair_unit_q  <= '0;
         pair_count_q <= '0;
         complete_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         num_cols_q   <= num_cols_d;
         col_cnt_q    <= col_cnt_d;
         rr_disp_q    <= rr_disp_d;
         rr_ret_q     <= rr_ret_d;
         owned_q      <= owned_d;
         pending_q    <= pending_d;
         zero_q       <= zero_d;
         pivot_q      <= pivot_d;
         col_of_q     <= col_of_d;
         hold_q       <= hold_d;
         hold_unit_q  <= hold_unit_d;
         pair_valid_q <= pair_valid_d;
         pair_birth_q <= pair_birth_d;
         pair_death_q <= pair_death_d;
         pair_unit_q  <= pair_unit_d;
         pair_count_q <= pair_count_d;
         complete_q   <= complete_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_reduction_dispatch_scheduler.sv
// Directed bench for reduction_dispatch_scheduler with hand-computed expectations.
// A small unit responder answers dispatches for the 20-column run.
module tb_reduction_dispatch_scheduler;

   localparam int NU = 8;
   localparam int AW = 12;

   logic              clk = 1'b0;
   logic              rst_n, start, dispatch_ready, pair_ready;
   logic [AW-1:0]     num_columns;
   logic [NU-1:0]     stim_done, stim_zero;
   logic [NU*AW-1:0]  stim_pivot;
   logic [NU-1:0]     done_valid, done_zero;
   logic [NU*AW-1:0]  done_pivot;
   logic              dispatch_valid, pair_valid, busy, complete, err_spurious;
   logic [2:0]        dispatch_unit;
   logic [AW-1:0]     dispatch_col, pair_birth, pair_death;
   logic [AW:0]       pair_count;

   bit                resp_en;
   bit [NU-1:0]       resp_done;
   bit [AW-1:0]       resp_col [NU];
   int unsigned       resp_timer [NU];

   int n_checks = 0;
   int n_errors = 0;
   int cyc, cnt, idx;
   int exp4 [6];
   bit [19:0] seen;

   always #5 clk = ~clk;

   reduction_dispatch_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .num_columns    (num_columns),
      .dispatch_valid (dispatch_valid),
      .dispatch_ready (dispatch_ready),
      .dispatch_unit  (dispatch_unit),
      .dispatch_col   (dispatch_col),
      .done_valid     (done_valid),
      .done_zero      (done_zero),
      .done_pivot     (done_pivot),
      .pair_valid     (pair_valid),
      .pair_ready     (pair_ready),
      .pair_birth     (pair_birth),
      .pair_death     (pair_death),
      .busy           (busy),
      .complete       (complete),
      .err_spurious   (err_spurious),
      .pair_count     (pair_count)
   );

   always_comb begin
      done_valid = stim_done | resp_done;
      done_zero  = resp_en ? '0 : stim_zero;
      done_pivot = stim_pivot;
      if (resp_en) begin
         for (int u = 0; u < NU; u++) done_pivot[u*AW +: AW] = resp_col[u] + 12'd100;
      end
   end

   // Each dispatched unit reports completion 5 cycles after the transfer.
   always @(negedge clk) begin
      for (int u = 0; u < NU; u++) begin
         if (resp_timer[u] != 0) resp_timer[u] <= resp_timer[u] - 1;
         resp_done[u] <= (resp_timer[u] == 1);
      end
      if (resp_en && dispatch_valid && dispatch_ready) begin
         resp_timer[dispatch_unit] <= 5;
         resp_col[dispatch_unit]   <= dispatch_col;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_complete(input string tag);
      cyc = 0;
      while (!complete && cyc < 60) begin
         step();
         cyc++;
      end
      check(tag, complete, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; num_columns = '0; dispatch_ready = 1'b0; pair_ready = 1'b0;
      stim_done = '0; stim_zero = '0; stim_pivot = '0; resp_en = 1'b0;
      exp4 = '{0, 1, 3, 4, 6, 7};
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_dvalid", dispatch_valid, 0);
      check("rst_pvalid", pair_valid, 0);
      check("rst_complete", complete, 0);
      check("rst_count", pair_count, 0);
      check("rst_err", err_spurious, 0);
      rst_n = 1'b1;
      step();

      // Three columns, units never finish until drained by hand.
      num_columns = 3; dispatch_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      check("t1_busy", busy, 1);
      for (int k = 0; k < 3; k++) begin
         check("t1_dvalid", dispatch_valid, 1);
         check("t1_unit", dispatch_unit, k);
         check("t1_col", dispatch_col, k);
         if (k == 1) begin
            start = 1'b1;
            num_columns = 9;
         end
         step();
         start = 1'b0;
      end
      check("t1_drain_dvalid", dispatch_valid, 0);
      check("t1_drain_busy", busy, 1);
      stim_done = 8'h07; stim_zero = 8'hFF;
      step();
      stim_done = '0;
      cyc = 0; cnt = 0;
      while (!complete && cyc < 20) begin
         if (pair_valid) cnt++;
         step();
         cyc++;
      end
      check("t1_no_pairs", cnt, 0);
      check("t1_complete", complete, 1);
      check("t1_idle", busy, 0);
      check("t1_count", pair_count, 0);

      // Eight columns from rr=3, then all units done at once.
      num_columns = 8; stim_zero = '0; start = 1'b1;
      step();
      start = 1'b0;
      check("t2_complete_clr", complete, 0);
      for (int k = 0; k < 8; k++) begin
         check("t2_dunit", dispatch_unit, (3 + k) % 8);
         check("t2_dcol", dispatch_col, k);
         step();
      end
      check("t2_drain_dvalid", dispatch_valid, 0);
      pair_ready = 1'b1; stim_done = 8'hFF;
      for (int u = 0; u < NU; u++) stim_pivot[u*AW +: AW] = 12'(200 + u);
      step();
      stim_done = '0;
      check("t2_latency", pair_valid, 0);
      for (int k = 0; k < 8; k++) begin
         step();
         check("t2_pvalid", pair_valid, 1);
         check("t2_birth", pair_birth, 200 + ((3 + k) % 8));
         check("t2_death", pair_death, k);
      end
      step();
      check("t2_pvalid_end", pair_valid, 0);
      wait_complete("t2_complete");
      check("t2_count", pair_count, 8);

      // Back-pressure on pairs while more columns wait for a unit.
      num_columns = 10; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check("t3_dunit", dispatch_unit, (3 + k) % 8);
         step();
      end
      check("t3_all_owned", dispatch_valid, 0);
      check("t3_busy", busy, 1);
      dispatch_ready = 1'b0; pair_ready = 1'b0;
      stim_pivot = '0;
      stim_pivot[3*AW +: AW] = 12'd50;
      stim_pivot[4*AW +: AW] = 12'd60;
      stim_done = 8'h18;
      step();
      stim_done = '0;
      step();
      for (int k = 0; k < 10; k++) begin
         check("t3_hold_pvalid", pair_valid, 1);
         check("t3_hold_birth", pair_birth, 50);
         check("t3_hold_death", pair_death, 0);
         check("t3_hold_nodisp", dispatch_valid, 0);
         step();
      end
      pair_ready = 1'b1;
      step();
      check("t3_next_birth", pair_birth, 60);
      check("t3_next_death", pair_death, 1);
      check("t3_redisp_valid", dispatch_valid, 1);
      check("t3_redisp_unit", dispatch_unit, 3);
      check("t3_redisp_col", dispatch_col, 8);
      dispatch_ready = 1'b1;
      step();
      check("t3_redisp2_unit", dispatch_unit, 4);
      check("t3_redisp2_col", dispatch_col, 9);
      check("t3_pvalid_gap", pair_valid, 0);
      step();
      check("t3_drain", dispatch_valid, 0);
      stim_done = 8'hFF; stim_zero = 8'hFF;
      step();
      stim_done = '0;
      wait_complete("t3_complete");
      check("t3_count", pair_count, 2);

      // Eight columns from rr=5, columns 2 and 5 reduce to zero.
      num_columns = 8; start = 1'b1; stim_zero = '0;
      step();
      start = 1'b0;
      check("t4_first_unit", dispatch_unit, 5);
      repeat (8) step();
      stim_zero = 8'b1000_0100;
      for (int u = 0; u < NU; u++) stim_pivot[u*AW +: AW] = 12'(((u + 3) % 8) + 100);
      stim_done = 8'hFF;
      step();
      stim_done = '0;
      cyc = 0; idx = 0;
      while (!complete && cyc < 40) begin
         if (pair_valid) begin
            if (idx < 6) begin
               check("t4_death", pair_death, exp4[idx]);
               check("t4_birth", pair_birth, exp4[idx] + 100);
            end
            idx++;
         end
         step();
         cyc++;
      end
      check("t4_pairs_seen", idx, 6);
      check("t4_complete", complete, 1);
      check("t4_count", pair_count, 6);

      // Completion from a unit that owns nothing.
      stim_done = 8'h08;
      step();
      stim_done = '0;
      check("t4_err", err_spurious, 1);
      check("t4_err_nopair", pair_valid, 0);
      step();
      check("t4_err_sticky", err_spurious, 1);
      check("t4_err_nopair2", pair_valid, 0);

      // Twenty columns, units answer 5 cycles after dispatch with pivot=col+100.
      resp_en = 1'b1; num_columns = 20; start = 1'b1;
      step();
      start = 1'b0;
      check("t5_err_clr", err_spurious, 0);
      cyc = 0; cnt = 0; seen = '0;
      while (!complete && cyc < 500) begin
         if (pair_valid) begin
            check("t5_pair", pair_birth, pair_death + 100);
            if (pair_death < 20) seen[pair_death] = 1'b1;
            cnt++;
         end
         step();
         cyc++;
      end
      check("t5_complete", complete, 1);
      check("t5_pairs", cnt, 20);
      check("t5_distinct", $countones(seen), 20);
      check("t5_count", pair_count, 20);
      check("t5_err", err_spurious, 0);
      resp_en = 1'b0;

      // Empty pass.
      num_columns = 0; start = 1'b1;
      step();
      start = 1'b0;
      check("t6_empty_busy", busy, 1);
      check("t6_empty_nodisp", dispatch_valid, 0);
      check("t6_empty_complete0", complete, 0);
      step();
      check("t6_empty_complete", complete, 1);
      check("t6_empty_idle", busy, 0);
      check("t6_empty_count", pair_count, 0);

      // Reset in the middle of a pass with a pair on the output.
      num_columns = 5; dispatch_ready = 1'b1; pair_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      dispatch_ready = 1'b0;
      stim_zero = '0; stim_done = 8'hFF;
      step();
      stim_done = '0;
      step();
      check("t6_pre_pvalid", pair_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_busy", busy, 0);
      check("t6_async_pvalid", pair_valid, 0);
      check("t6_async_dvalid", dispatch_valid, 0);
      step();
      check("t6_rst_busy", busy, 0);
      check("t6_rst_err", err_spurious, 0);
      check("t6_rst_count", pair_count, 0);
      check("t6_rst_complete", complete, 0);
      check("t6_rst_pvalid", pair_valid, 0);
      rst_n = 1'b1; pair_ready = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (pair_valid || dispatch_valid) cnt++;
      end
      check("t6_after_rst_quiet", cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
